uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/mspu_uart_pkg.sv | 17 +
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_tx_buffered.sv | 139 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mspu_uart_pkg.sv
// rtl/mspu_uart_pkg.sv - shared types and constants for the buffered UART transmitter
// Purpose: transmitter FSM state encoding, memory-mapped UART address, default sizing.
// Ports: none (package).
package mspu_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic [31:0] UART_ADDR            = 32'h1000_0000;
  localparam int unsigned UART_CLK_DIV_DEFAULT = 868;  // 100 MHz / 115200 baud
  localparam int unsigned UART_FIFO_AW_DEFAULT = 4;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - single-clock register-array FIFO feeding the UART shifter
// Purpose: 2**AW entry FIFO with extra-MSB pointers so full and empty are unambiguous.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset (pointers only)
//   push_i, wdata_i      write request and data; ignored when full
//   pop_i, rdata_o       read request and head-of-queue data; ignored when empty
//   full_o, empty_o      occupancy flags
//   level_o              current occupancy, 0..2**AW
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter
// Purpose: accepts byte stores from the core, queues them and shifts them out LSB first.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   uart_dout, uart_we   store word (bits [7:0] used) and its one-cycle write strobe
//   txd                  serial line, idle high, driven from a flop
//   busy                 frame on the line or bytes still queued
//   full, level          FIFO full flag and occupancy
//   overflow             sticky, set when a write hits a full FIFO
module uart_tx_buffered
  import mspu_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int unsigned FIFO_AW = UART_FIFO_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        uart_dout,
  input  logic               uart_we,
  output logic               txd,
  output logic               busy,
  output logic               full,
  output logic               overflow,
  output logic [FIFO_AW:0]   level
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  uart_tx_state_t state_q;
  logic [15:0]    cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic           txd_q;
  logic           busy_q;
  logic           overflow_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rdata;
  logic           push;
  logic           pop;
  logic           bit_end;
  logic           unused_hi;

  assign unused_hi = ^uart_dout[31:8];

  assign push    = uart_we && !fifo_full;
  assign bit_end = (cnt_q == DIV_LAST);
  // Pop when leaving IDLE or at the end of a stop bit, so queued frames run back to back.
  assign pop     = !fifo_empty &&
                   ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  uart_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (uart_we),
    .wdata_i (uart_dout[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // txd is registered from the current state, so the line lags the FSM by one
  // cycle; busy follows the same lag so it drops only once the stop bit is over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    txd_q <= 1'b1;
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[idx_q];
        default: txd_q <= 1'b1;
      endcase

      busy_q <= (state_q != IDLE) || !fifo_empty || push;

      if (uart_we && fifo_full) overflow_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) state_q <= STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_rdata;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
  localparam int FRAME   = 10 * CLK_DIV;

  logic               clk;
  logic               reset_n;
  logic [31:0]        uart_dout;
  logic               uart_we;
  logic               txd;
  logic               busy;
  logic               full;
  logic               overflow;
  logic [FIFO_AW:0]   level;

  uart_tx_buffered #(
    .CLK_DIV (CLK_DIV),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_dout (uart_dout),
    .uart_we   (uart_we),
    .txd       (txd),
    .busy      (busy),
    .full      (full),
    .overflow  (overflow),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp_byte;
  } vec_t;

  wr_t          sched[$];
  logic [7:0]   exp_q[$];
  vec_t         vecs[4];

  logic         txd_log  [256];
  logic         busy_log [256];
  logic         full_log [256];
  logic         ovf_log  [256];
  logic [FIFO_AW:0] lvl_log [256];

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Log index k holds the values sampled just after the k-th active edge of the run;
  // a write scheduled at k is presented so that edge k samples it.
  task automatic run(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      uart_we = 1'b0;
      foreach (sched[i]) begin
        if (sched[i].k == k) begin
          uart_we   = 1'b1;
          uart_dout = sched[i].d;
        end
      end
      @(posedge clk);
      #1;
      txd_log[k]  = txd;
      busy_log[k] = busy;
      full_log[k] = full;
      ovf_log[k]  = overflow;
      lvl_log[k]  = level;
    end
    uart_we = 1'b0;
    sched.delete();
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j < CLK_DIV)           return 1'b0;
    else if (j < 9 * CLK_DIV)  return b[(j - CLK_DIV) / CLK_DIV];
    else                       return 1'b1;
  endfunction

  // First start bit is on the line two edges after the first write (log index 2);
  // queued frames follow with no gap.
  task automatic check_line(input string name, input int ncyc);
    int nbad;
    int first_bad;
    logic e;
    nbad = 0;
    first_bad = -1;
    for (int k = 0; k < ncyc; k++) begin
      int idx;
      idx = k - 2;
      if (idx < 0 || idx >= FRAME * exp_q.size()) e = 1'b1;
      else e = frame_bit(exp_q[idx / FRAME], idx % FRAME);
      if (txd_log[k] !== e) begin
        nbad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (nbad != 0) $display("line %s: first bad bit at cycle %0d", name, first_bad);
    check(name, nbad, 0);
    exp_q.delete();
  endtask

  initial begin
    int maxlvl;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{32'h0000_00A5, 8'hA5};
    vecs[1] = '{32'h1234_5600, 8'h00};
    vecs[2] = '{32'hFFFF_FF3C, 8'h3C};
    vecs[3] = '{32'h0000_0081, 8'h81};

    reset_n   = 1'b0;
    uart_we   = 1'b0;
    uart_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", level, 0);
    reset_n = 1'b1;

    // Single frames: exact waveform, latency and busy fall.
    foreach (vecs[v]) begin
      sched.push_back('{0, vecs[v].din});
      run(FRAME + 4);
      exp_q.push_back(vecs[v].exp_byte);
      check_line($sformatf("single_line_%0d", v), FRAME + 4);
      check($sformatf("single_busy_hi_%0d", v), busy_log[FRAME + 1], 1);
      check($sformatf("single_busy_lo_%0d", v), busy_log[FRAME + 2], 0);
    end

    // Three back-to-back writes.
    sched.push_back('{0, 32'h41});
    sched.push_back('{1, 32'h42});
    sched.push_back('{2, 32'h43});
    run(3 * FRAME + 4);
    maxlvl = 0;
    for (int k = 0; k < 3 * FRAME + 4; k++) if (int'(lvl_log[k]) > maxlvl) maxlvl = int'(lvl_log[k]);
    check("b2b_level_peak", maxlvl, 2);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    check_line("b2b_line", 3 * FRAME + 4);
    check("b2b_busy_hi", busy_log[3 * FRAME + 1], 1);
    check("b2b_busy_lo", busy_log[3 * FRAME + 2], 0);

    // Six writes while idle: one popped, four buffered, one dropped.
    for (int i = 0; i < 6; i++) sched.push_back('{i, 32'h10 + i});
    run(5 * FRAME + 8);
    check("ovf_full_before", full_log[3], 0);
    check("ovf_full", full_log[4], 1);
    check("ovf_level", lvl_log[5], 4);
    check("ovf_flag_before", ovf_log[4], 0);
    check("ovf_flag", ovf_log[5], 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
    check_line("ovf_line", 5 * FRAME + 8);
    check("ovf_busy_lo", busy_log[5 * FRAME + 2], 0);

    // Push coincident with the pop at the end of the first stop bit.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    sched.push_back('{0, 32'h41});
    sched.push_back('{1, 32'h42});
    sched.push_back('{2, 32'h43});
    sched.push_back('{FRAME + 1, 32'h44});
    run(4 * FRAME + 6);
    check("pushpop_level_before", lvl_log[FRAME], 2);
    check("pushpop_level", lvl_log[FRAME + 1], 2);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    check_line("pushpop_line", 4 * FRAME + 6);

    // Reset during data bit 3 of a 0x00 frame with the FIFO full and overflow set.
    for (int i = 0; i < 6; i++) sched.push_back('{i, 32'h0});
    run(19);
    check("midrst_txd_before", txd_log[18], 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_level", level, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sched.push_back('{0, 32'hFF});
    run(FRAME + 4);
    exp_q.push_back(8'hFF);
    check_line("midrst_after_line", FRAME + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
